// File: rtl/sorter_pkg.sv
// sorter_pkg: shared width helpers and sort-direction encoding for the stream sorter
package sorter_pkg;

    localparam logic SORT_ASC  = 1'b0;
    localparam logic SORT_DESC = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // index width rule: enough bits to name every lane, never narrower than one bit
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/compare_swap.sv
// compare_swap: stable compare-exchange of one (key, lane-tag) pair in the chosen direction
module compare_swap
    import sorter_pkg::*;
#(
    parameter int DW = 8,
    parameter int IW = 2
) (
    input  logic [DW-1:0] a_key,
    input  logic [IW-1:0] a_idx,
    input  logic [DW-1:0] b_key,
    input  logic [IW-1:0] b_idx,
    input  logic          desc,
    output logic [DW-1:0] lo_key,
    output logic [IW-1:0] lo_idx,
    output logic [DW-1:0] hi_key,
    output logic [IW-1:0] hi_idx
);

    logic swap;

    // strict compares leave equal keys in place, which keeps the sort stable
    assign swap   = (desc == SORT_DESC) ? (a_key < b_key) : (a_key > b_key);
    assign lo_key = swap ? b_key : a_key;
    assign lo_idx = swap ? b_idx : a_idx;
    assign hi_key = swap ? a_key : b_key;
    assign hi_idx = swap ? a_idx : b_idx;

endmodule

// File: rtl/stream_sorter.sv
// stream_sorter: pipelined odd-even transposition sorter with lane tags and full backpressure
module stream_sorter
    import sorter_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int DW = 8,
    localparam int IW = idx_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW*N-1:0] in_data,
    input  logic            in_desc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW*N-1:0] out_data,
    output logic [IW*N-1:0] out_idx,
    output logic            out_desc
);

    typedef logic [N-1:0][DW-1:0] keys_t;
    typedef logic [N-1:0][IW-1:0] idxs_t;

    keys_t      key_q [0:N];
    idxs_t      idx_q [0:N];
    logic [N:0] desc_q;
    logic [N:0] vld_q;
    keys_t      key_d [0:N-1];
    idxs_t      idx_d [0:N-1];
    idxs_t      lane_ids;
    logic       en;

    assign en        = out_ready || !vld_q[N];
    assign in_ready  = en;
    assign out_valid = vld_q[N];
    assign out_data  = key_q[N];
    assign out_idx   = idx_q[N];
    assign out_desc  = desc_q[N];

    // each accepted lane is tagged with its own position
    always_comb begin
        for (int i = 0; i < N; i++) lane_ids[i] = IW'(i);
    end

    // layer s pairs lanes starting at its parity; an unpaired edge lane passes straight through
    for (genvar s = 0; s < N; s++) begin : g_stage
        for (genvar k = 0; k < N; k++) begin : g_lane
            if ((k % 2) == (s % 2) && k + 1 < N) begin : g_pair
                compare_swap #(.DW(DW), .IW(IW)) u_cs (
                    .a_key  (key_q[s][k]),
                    .a_idx  (idx_q[s][k]),
                    .b_key  (key_q[s][k+1]),
                    .b_idx  (idx_q[s][k+1]),
                    .desc   (desc_q[s]),
                    .lo_key (key_d[s][k]),
                    .lo_idx (idx_d[s][k]),
                    .hi_key (key_d[s][k+1]),
                    .hi_idx (idx_d[s][k+1])
                );
            end else if (!(k >= 1 && ((k - 1) % 2) == (s % 2))) begin : g_pass
                assign key_d[s][k] = key_q[s][k];
                assign idx_d[s][k] = idx_q[s][k];
            end
        end
    end

    // bank 0 captures the raw tagged vector, bank s+1 captures layer s; everything shifts together on en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            desc_q <= '0;
            for (int i = 0; i <= N; i++) begin
                key_q[i] <= '0;
                idx_q[i] <= '0;
            end
        end else if (en) begin
            vld_q    <= {vld_q[N-1:0], in_valid};
            desc_q   <= {desc_q[N-1:0], in_desc};
            key_q[0] <= in_data;
            idx_q[0] <= lane_ids;
            for (int i = 0; i < N; i++) begin
                key_q[i+1] <= key_d[i];
                idx_q[i+1] <= idx_d[i];
            end
        end
    end

endmodule

// File: tb/tb_stream_sorter.sv
// tb_stream_sorter: scoreboard bench for the 4-lane, 8-bit stream sorter
module tb_stream_sorter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_desc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_idx;
    logic        out_desc;

    int pass_cnt = 0;
    int total_cnt = 0;
    int vcount = 0;

    logic [31:0] q_data [$];
    logic [7:0]  q_idx  [$];
    logic        q_desc [$];

    stream_sorter #(.N(4), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_desc  (out_desc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: stable insertion sort of (key, lane) pairs
    function automatic void model(input logic [31:0] d, input logic ds,
                                  output logic [31:0] od, output logic [7:0] oi);
        logic [7:0] k [4];
        logic [1:0] x [4];
        logic [7:0] tk;
        logic [1:0] tx;
        for (int i = 0; i < 4; i++) begin
            k[i] = d[8*i +: 8];
            x[i] = 2'(i);
        end
        for (int i = 1; i < 4; i++)
            for (int j = i; j > 0; j--)
                if (ds ? (k[j-1] < k[j]) : (k[j-1] > k[j])) begin
                    tk = k[j]; k[j] = k[j-1]; k[j-1] = tk;
                    tx = x[j]; x[j] = x[j-1]; x[j-1] = tx;
                end
        for (int i = 0; i < 4; i++) begin
            od[8*i +: 8] = k[i];
            oi[2*i +: 2] = x[i];
        end
    endfunction

    task automatic push(input logic [31:0] d, input logic ds);
        logic [31:0] od;
        logic [7:0]  oi;
        model(d, ds, od, oi);
        q_data.push_back(od);
        q_idx.push_back(oi);
        q_desc.push_back(ds);
    endtask

    // scoreboard: every emitted vector must be the next expected one
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total_cnt++;
            if (q_data.size() == 0) begin
                $display("FAIL sb_extra: got data=%h idx=%h desc=%b, required no output", out_data, out_idx, out_desc);
            end else begin
                logic [31:0] ed;
                logic [7:0]  ei;
                logic        es;
                ed = q_data.pop_front();
                ei = q_idx.pop_front();
                es = q_desc.pop_front();
                if (out_data !== ed || out_idx !== ei || out_desc !== es)
                    $display("FAIL sb_compare: got data=%h idx=%h desc=%b, required data=%h idx=%h desc=%b",
                             out_data, out_idx, out_desc, ed, ei, es);
                else
                    pass_cnt++;
            end
        end
    end

    always @(negedge clk) if (rst_n && out_valid) vcount++;

    // send one vector and wait for the first output, returning what appeared and how many edges it took
    task automatic run_one(input logic [31:0] d, input logic ds,
                           output logic [31:0] od, output logic [7:0] oi,
                           output logic osd, output int lat);
        @(posedge clk); #1;
        in_data = d; in_desc = ds; in_valid = 1'b1;
        push(d, ds);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        od = out_data; oi = out_idx; osd = out_desc;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_idx !== 8'h0 || out_desc !== 1'b0)
            $display("FAIL reset_outputs: got valid=%b data=%h idx=%h desc=%b, required all 0", out_valid, out_data, out_idx, out_desc);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL post_reset_idle: got valid=%b ready=%b, required 0/1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_ascending();
        logic [31:0] od; logic [7:0] oi; logic osd; int lat;
        run_one({8'h10, 8'h03, 8'hFF, 8'h42}, 1'b0, od, oi, osd, lat);
        total_cnt++;
        if (lat !== 4) $display("FAIL asc_latency: got %0d, required 4", lat); else pass_cnt++;
        total_cnt++;
        if (od !== {8'hFF, 8'h42, 8'h10, 8'h03}) $display("FAIL asc_data: got %h, required ff421003", od); else pass_cnt++;
        total_cnt++;
        if (oi !== {2'd1, 2'd0, 2'd3, 2'd2}) $display("FAIL asc_idx: got %h, required %h", oi, {2'd1, 2'd0, 2'd3, 2'd2}); else pass_cnt++;
        total_cnt++;
        if (osd !== 1'b0) $display("FAIL asc_desc: got %b, required 0", osd); else pass_cnt++;
    endtask

    task automatic test_descending();
        logic [31:0] od; logic [7:0] oi; logic osd; int lat;
        run_one({8'h10, 8'h03, 8'hFF, 8'h42}, 1'b1, od, oi, osd, lat);
        total_cnt++;
        if (od !== {8'h03, 8'h10, 8'h42, 8'hFF}) $display("FAIL desc_data: got %h, required 031042ff", od); else pass_cnt++;
        total_cnt++;
        if (oi !== {2'd2, 2'd3, 2'd0, 2'd1}) $display("FAIL desc_idx: got %h, required %h", oi, {2'd2, 2'd3, 2'd0, 2'd1}); else pass_cnt++;
        total_cnt++;
        if (osd !== 1'b1) $display("FAIL desc_flag: got %b, required 1", osd); else pass_cnt++;
    endtask

    task automatic test_ties();
        logic [31:0] od; logic [7:0] oi; logic osd; int lat;
        for (int m = 0; m < 2; m++) begin
            run_one(32'h55555555, m[0], od, oi, osd, lat);
            total_cnt++;
            if (od !== 32'h55555555 || oi !== {2'd3, 2'd2, 2'd1, 2'd0})
                $display("FAIL ties_equal_dir%0d: got data=%h idx=%h, required 55555555/e4", m, od, oi);
            else pass_cnt++;
        end
        run_one({8'h02, 8'h07, 8'h02, 8'h07}, 1'b0, od, oi, osd, lat);
        total_cnt++;
        if (od !== {8'h07, 8'h07, 8'h02, 8'h02}) $display("FAIL ties_pairs_data: got %h, required 07070202", od); else pass_cnt++;
        total_cnt++;
        if (oi !== {2'd2, 2'd0, 2'd3, 2'd1}) $display("FAIL ties_pairs_idx: got %h, required %h", oi, {2'd2, 2'd0, 2'd3, 2'd1}); else pass_cnt++;
    endtask

    task automatic test_streaming();
        logic [31:0] vbits;
        int first;
        int run;
        vbits = '0;
        @(posedge clk); #1;
        for (int c = 0; c < 24; c++) begin
            if (c < 8) begin
                in_data = $urandom; in_desc = c[0]; in_valid = 1'b1;
                push(in_data, in_desc);
            end else in_valid = 1'b0;
            @(posedge clk); #1;
            vbits[c] = out_valid;
        end
        first = -1;
        for (int c = 0; c < 24; c++) if (first < 0 && vbits[c]) first = c;
        run = 0;
        if (first >= 0) for (int c = first; c < 24 && vbits[c]; c++) run++;
        total_cnt++;
        if (run !== 8) $display("FAIL stream_run: got %0d consecutive valid cycles, required 8", run); else pass_cnt++;
        total_cnt++;
        if ($countones(vbits) !== 8) $display("FAIL stream_count: got %0d valid cycles, required 8", $countones(vbits)); else pass_cnt++;
        total_cnt++;
        if (q_data.size() !== 0) $display("FAIL stream_drain: got %0d pending, required 0", q_data.size()); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] sd; logic [7:0] si; logic ss;
        int w;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 12 && in_ready; i++) begin
            in_data = $urandom; in_desc = $urandom_range(0, 1); in_valid = 1'b1;
            push(in_data, in_desc);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL bp_full: got valid=%b ready=%b, required 1/0", out_valid, in_ready);
        else pass_cnt++;
        sd = out_data; si = out_idx; ss = out_desc;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== sd || out_idx !== si || out_desc !== ss)
                $display("FAIL bp_hold%0d: got ready=%b valid=%b data=%h idx=%h desc=%b, required 0/1/%h/%h/%b",
                         c, in_ready, out_valid, out_data, out_idx, out_desc, sd, si, ss);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = $urandom; in_desc = i[0]; in_valid = 1'b1;
            push(in_data, in_desc);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        w = 0;
        while (q_data.size() != 0 && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        total_cnt++;
        if (q_data.size() !== 0) $display("FAIL bp_drain: got %0d pending, required 0", q_data.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] od; logic [7:0] oi; logic osd; int lat;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom; in_desc = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_idx !== 8'h0 || out_desc !== 1'b0)
            $display("FAIL midrst_outputs: got valid=%b data=%h idx=%h desc=%b, required all 0", out_valid, out_data, out_idx, out_desc);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b, required 1", in_ready); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        run_one({8'h01, 8'h80, 8'h7F, 8'hC0}, 1'b1, od, oi, osd, lat);
        total_cnt++;
        if (lat !== 4) $display("FAIL midrst_latency: got %0d, required 4", lat); else pass_cnt++;
        repeat (8) @(posedge clk);
        #1;
        total_cnt++;
        if (vcount !== 1) $display("FAIL midrst_ghosts: got %0d valid cycles, required 1", vcount); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_desc = 1'b0; out_ready = 1'b1;
        test_reset();
        test_ascending();
        test_descending();
        test_ties();
        test_streaming();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
